// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time program loader: loader FSM states,
// frame target codes and memory word-address width.
package mips_pkg;

    localparam int unsigned MEM_AW = 8;

    localparam logic [7:0] TGT_INSTR = 8'h00;
    localparam logic [7:0] TGT_DATA  = 8'h01;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_HOLD,
        S_DONE,
        S_ERROR
    } loader_state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic state_accepts(input loader_state_t s);
        return (s == S_IDLE) || (s == S_ADDR) || (s == S_COUNT) ||
               (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// byte_word_packer: collects four bytes, MSB first, into a 32-bit word.
// word_valid pulses for one cycle after the fourth byte has been shifted in;
// word holds its value until the next byte arrives.
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_word_valid;

    // Shift accepted bytes in and count position within the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= in_valid && (r_cnt == 2'd3);
            if (in_valid) begin
                r_shift <= {r_shift[23:0], in_data};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign last_byte  = (r_cnt == 2'd3);
    assign word_valid = r_word_valid;
    assign word       = r_shift;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for instruction/data memory.
// Frame: TARGET, START, COUNT (0 = 256 words), then 4*COUNT payload bytes.
// Optional IMEM_LOADER_CHECKSUM_EN appends an XOR-of-payload byte that must
// match before the core is released.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              instr_write_enable,
    output logic [MEM_AW-1:0] instr_write_addr,
    output logic [31:0]       instr_write_data,
    output logic              data_init_write_enable,
    output logic [MEM_AW-1:0] data_init_addr,
    output logic [31:0]       data_init_data,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [3:0] HOLD_LAST = 4'(RELEASE_DELAY - 1);

    loader_state_t     r_state, w_next;
    logic              r_in_ready;
    logic              r_target;
    logic [MEM_AW-1:0] r_start;
    logic [MEM_AW-1:0] r_widx;
    logic [8:0]        r_words_left;
    logic [3:0]        r_hold_cnt;
    logic              r_iwe, r_dwe;
    logic [MEM_AW-1:0] r_iaddr, r_daddr;
    logic [31:0]       r_idata, r_ddata;
    logic              r_core_reset, r_done, r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_accept;
    logic              w_pack_in;
    logic              w_pack_last;
    logic              w_pack_valid;
    logic [31:0]       w_word;
    logic [MEM_AW-1:0] w_addr;

    assign w_accept  = in_valid && r_in_ready;
    assign w_pack_in = w_accept && (r_state == S_DATA);
    assign w_addr    = r_start + r_widx;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (w_pack_in),
        .last_byte  (w_pack_last),
        .word_valid (w_pack_valid),
        .word       (w_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode from the frame stream and word bookkeeping.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)
                         w_next = (in_data == TGT_INSTR || in_data == TGT_DATA) ? S_ADDR : S_ERROR;
            S_ADDR:  if (w_accept) w_next = S_COUNT;
            S_COUNT: if (w_accept) w_next = S_DATA;
            S_DATA:  if (w_accept && w_pack_last) w_next = S_WRITE;
            S_WRITE: begin
                if (r_words_left == 9'd1)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_HOLD;
`endif
                else
                    w_next = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: if (w_accept) w_next = (in_data == r_csum) ? S_HOLD : S_ERROR;
`endif
            S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_next = S_DONE;
            default: w_next = r_state;
        endcase
    end

    // Header capture, memory write pulses, release timing and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready   <= 1'b0;
            r_target     <= 1'b0;
            r_start      <= '0;
            r_widx       <= '0;
            r_words_left <= '0;
            r_hold_cnt   <= '0;
            r_iwe        <= 1'b0;
            r_dwe        <= 1'b0;
            r_iaddr      <= '0;
            r_idata      <= '0;
            r_daddr      <= '0;
            r_ddata      <= '0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_in_ready   <= state_accepts(w_next);
            r_core_reset <= (w_next != S_DONE);
            if (w_next == S_DONE)  r_done  <= 1'b1;
            if (w_next == S_ERROR) r_error <= 1'b1;
            r_iwe <= 1'b0;
            r_dwe <= 1'b0;
            case (r_state)
                S_IDLE:  if (w_accept) r_target <= in_data[0];
                S_ADDR:  if (w_accept) begin
                             r_start <= in_data;
                             r_widx  <= '0;
                         end
                S_COUNT: if (w_accept)
                             r_words_left <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                S_WRITE: if (w_pack_valid) begin
                             if (r_target) begin
                                 r_dwe   <= 1'b1;
                                 r_daddr <= w_addr;
                                 r_ddata <= w_word;
                             end else begin
                                 r_iwe   <= 1'b1;
                                 r_iaddr <= w_addr;
                                 r_idata <= w_word;
                             end
                             r_widx       <= r_widx + 1'b1;
                             r_words_left <= r_words_left - 9'd1;
                             r_hold_cnt   <= '0;
                         end
                S_HOLD:  r_hold_cnt <= r_hold_cnt + 4'd1;
                default: ;
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_pack_in) r_csum <= r_csum ^ in_data;
`endif
        end
    end

    assign in_ready               = r_in_ready;
    assign instr_write_enable     = r_iwe;
    assign instr_write_addr       = r_iaddr;
    assign instr_write_data       = r_idata;
    assign data_init_write_enable = r_dwe;
    assign data_init_addr         = r_daddr;
    assign data_init_data         = r_ddata;
    assign core_reset             = r_core_reset;
    assign load_done              = r_done;
    assign load_error             = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected writes are derived from each
// frame (START + i mod 256, payload words) and matched by a monitor on every
// write pulse; status/release timing is checked per frame.
module tb_imem_loader;

    localparam int unsigned RD = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        instr_write_enable;
    logic [7:0]  instr_write_addr;
    logic [31:0] instr_write_data;
    logic        data_init_write_enable;
    logic [7:0]  data_init_addr;
    logic [31:0] data_init_data;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    imem_loader #(.RELEASE_DELAY(RD)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .instr_write_enable     (instr_write_enable),
        .instr_write_addr       (instr_write_addr),
        .instr_write_data       (instr_write_data),
        .data_init_write_enable (data_init_write_enable),
        .data_init_addr         (data_init_addr),
        .data_init_data         (data_init_data),
        .core_reset             (core_reset),
        .load_done              (load_done),
        .load_error             (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          tgt;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] payload [0:255];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_word_cyc = 0;
    int          csum_cyc = 0;
    int          last_pulse_cyc = 0;
    int          n_ipulses = 0;
    int          n_dpulses = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write pulse must match the next expected write.
    logic prev_en = 1'b0;
    wr_t  mw;
    always @(negedge clk) begin
        if (instr_write_enable || data_init_write_enable) begin
            chk("one_enable", {31'b0, instr_write_enable & data_init_write_enable}, 32'd0);
            chk("pulse_width", {31'b0, prev_en}, 32'd0);
            chk("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            chk("write_latency", cyc, last_word_cyc + 1);
            if (exp_q.size() != 0) begin
                mw = exp_q.pop_front();
                chk("write_target", {31'b0, data_init_write_enable}, {31'b0, mw.tgt});
                if (data_init_write_enable) begin
                    chk("data_addr", {24'b0, data_init_addr}, {24'b0, mw.addr});
                    chk("data_word", data_init_data, mw.data);
                    chk("unsel_instr_addr", {24'b0, instr_write_addr}, 32'd0);
                    chk("unsel_instr_data", instr_write_data, 32'd0);
                end else begin
                    chk("instr_addr", {24'b0, instr_write_addr}, {24'b0, mw.addr});
                    chk("instr_word", instr_write_data, mw.data);
                    chk("unsel_data_addr", {24'b0, data_init_addr}, 32'd0);
                    chk("unsel_data_data", data_init_data, 32'd0);
                end
            end
            last_pulse_cyc = cyc;
            if (instr_write_enable) n_ipulses++;
            if (data_init_write_enable) n_dpulses++;
        end
        prev_en = instr_write_enable || data_init_write_enable;
    end

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_iwe", {31'b0, instr_write_enable}, 32'd0);
        chk("rst_dwe", {31'b0, data_init_write_enable}, 32'd0);
        chk("rst_iaddr", {24'b0, instr_write_addr}, 32'd0);
        chk("rst_idata", instr_write_data, 32'd0);
        chk("rst_daddr", {24'b0, data_init_addr}, 32'd0);
        chk("rst_ddata", data_init_data, 32'd0);
        chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_error", {31'b0, load_error}, 32'd0);
        reset = 1'b0;
        chk("ready_after_deassert", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_next_cycle", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 64) begin @(posedge clk); #1; waited++; end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        if (in_ready) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] tgt, input logic [7:0] start,
                              input int nwords, input int max_gap, input logic [7:0] csum_flip);
        wr_t        w;
        logic [7:0] x;
        logic [7:0] bt;
        x = '0;
        for (int i = 0; i < nwords; i++) begin
            w.tgt  = tgt[0];
            w.addr = start + 8'(i);
            w.data = payload[i];
            exp_q.push_back(w);
        end
        send_byte(tgt, max_gap);
        send_byte(start, max_gap);
        send_byte((nwords == 256) ? 8'h00 : 8'(nwords), max_gap);
        for (int i = 0; i < nwords; i++) begin
            for (int b = 0; b < 4; b++) begin
                bt = payload[i][31 - 8*b -: 8];
                x  = x ^ bt;
                send_byte(bt, max_gap);
                if (b == 3) last_word_cyc = acc_cyc;
            end
        end
        if (CSUM) begin
            send_byte(x ^ csum_flip, max_gap);
            csum_cyc = acc_cyc;
        end
    endtask

    task automatic wait_result(input bit exp_done);
        int waited;
        int rel_ref;
        waited = 0;
        while (!(load_done || load_error) && waited < 400) begin
            chk("core_reset_held", {31'b0, core_reset}, 32'd1);
            @(posedge clk); #1;
            waited++;
        end
        chk("load_done", {31'b0, load_done}, {31'b0, exp_done});
        chk("load_error", {31'b0, load_error}, {31'b0, !exp_done});
        chk("core_reset_end", {31'b0, core_reset}, {31'b0, !exp_done});
        chk("in_ready_end", {31'b0, in_ready}, 32'd0);
        chk("writes_pending", exp_q.size(), 32'd0);
        if (exp_done) begin
            rel_ref = CSUM ? csum_cyc : last_pulse_cyc;
            chk("release_delay", 32'(cyc - rel_ref), RD);
        end
    endtask

    int ip0, dp0;

    initial begin
        do_reset();

        // Instruction load from the reference stream.
        ip0 = n_ipulses; dp0 = n_dpulses;
        payload[0] = 32'h2001000A;
        payload[1] = 32'h8C040000;
        send_frame(8'h00, 8'h10, 2, 0, 8'h00);
        wait_result(1'b1);
        chk("t1_iaddr_last", {24'b0, instr_write_addr}, 32'h11);
        chk("t1_idata_last", instr_write_data, 32'h8C040000);
        chk("t1_instr_pulses", n_ipulses - ip0, 32'd2);
        chk("t1_data_pulses", n_dpulses - dp0, 32'd0);

        // Data target, address wraps 0xFF -> 0x00.
        do_reset();
        dp0 = n_dpulses;
        payload[0] = 32'h11223344;
        payload[1] = 32'h55667788;
        send_frame(8'h01, 8'hFF, 2, 0, 8'h00);
        wait_result(1'b1);
        chk("t2_daddr_last", {24'b0, data_init_addr}, 32'h00);
        chk("t2_ddata_last", data_init_data, 32'h55667788);
        chk("t2_data_pulses", n_dpulses - dp0, 32'd2);

        // Bad target byte.
        do_reset();
        ip0 = n_ipulses; dp0 = n_dpulses;
        send_byte(8'h07, 0);
        chk("t3_error", {31'b0, load_error}, 32'd1);
        chk("t3_in_ready", {31'b0, in_ready}, 32'd0);
        chk("t3_core_reset", {31'b0, core_reset}, 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        chk("t3_error_sticky", {31'b0, load_error}, 32'd1);
        chk("t3_done", {31'b0, load_done}, 32'd0);
        chk("t3_core_reset_late", {31'b0, core_reset}, 32'd1);
        chk("t3_no_pulses", (n_ipulses - ip0) + (n_dpulses - dp0), 32'd0);

        // Randomly stalled stream.
        do_reset();
        payload[0] = 32'h01234567;
        payload[1] = 32'h89ABCDEF;
        payload[2] = 32'hA5A55A5A;
        send_frame(8'h00, 8'h40, 3, 3, 8'h00);
        wait_result(1'b1);
        chk("t4_iaddr_last", {24'b0, instr_write_addr}, 32'h42);

        // Reset after two payload bytes, then a clean frame.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        ip0 = n_ipulses;
        payload[0] = 32'hCAFEBABE;
        send_frame(8'h01, 8'h30, 1, 0, 8'h00);
        wait_result(1'b1);
        chk("t5_daddr", {24'b0, data_init_addr}, 32'h30);
        chk("t5_ddata", data_init_data, 32'hCAFEBABE);
        chk("t5_no_instr", n_ipulses - ip0, 32'd0);

        // COUNT = 0 means 256 words, wrapping through the whole address space.
        do_reset();
        dp0 = n_dpulses;
        for (int i = 0; i < 256; i++) payload[i] = (32'h9E3779B9 * i) ^ 32'h5A5A0F0F;
        send_frame(8'h01, 8'h80, 256, 0, 8'h00);
        wait_result(1'b1);
        chk("t6_data_pulses", n_dpulses - dp0, 32'd256);
        chk("t6_daddr_last", {24'b0, data_init_addr}, 32'h7F);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum 0x22 matches DE^AD^BE^EF.
        do_reset();
        payload[0] = 32'hDEADBEEF;
        send_frame(8'h00, 8'h00, 1, 0, 8'h00);
        wait_result(1'b1);
        chk("t7_idata", instr_write_data, 32'hDEADBEEF);

        // Checksum 0x23 is rejected; the word is still committed.
        do_reset();
        ip0 = n_ipulses;
        send_frame(8'h00, 8'h00, 1, 0, 8'h01);
        wait_result(1'b0);
        chk("t8_instr_pulses", n_ipulses - ip0, 32'd1);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that is the writing side of the MIPS core's memory-initialisation port. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into instruction memory (`instr_write_*`) or data memory (`data_init_*`) with a one-cycle write-enable pulse. The loader holds the core in reset until the frame completes and releases it only after a successful load.

## Interface
- `RELEASE_DELAY`, default 2: clock cycles between the last committed write and `core_reset` deassertion; legal range 1..15.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `instr_write_enable` out 1: one-cycle write pulse to instruction memory.
- `instr_write_addr` out 8: instruction-memory word address.
- `instr_write_data` out 32: instruction word.
- `data_init_write_enable` out 1: one-cycle write pulse to data memory.
- `data_init_addr` out 8: data-memory word address.
- `data_init_data` out 32: data word.
- `core_reset` out 1: active-high reset to the processor.
- `load_done` out 1: sticky; frame loaded successfully.
- `load_error` out 1: sticky; frame rejected.

## Operation
- Frame layout: TARGET byte (0x00 = instr, 0x01 = data), START address byte, COUNT byte (0x00 means 256 words), then 4×N payload bytes, MSB first.
- States:
  - IDLE → ADDR on any TARGET byte of 0x00 or 0x01. Any other TARGET value → ERROR.
  - ADDR → COUNT on the START byte.
  - COUNT → DATA on the COUNT byte.
  - DATA shifts in bytes. After the 4th byte → WRITE.
  - WRITE pulses the enable for the selected target for one cycle. Address = START + word index, mod 256 (wraps 0xFF → 0x00). Next state is DATA if words remain, otherwise CHECK (macro on) or HOLD.
  - HOLD counts `RELEASE_DELAY` cycles → DONE.
  - DONE and ERROR are terminal until `reset`.
- Only the selected target's enable ever pulses. The unselected target's addr/data stay 0.
- Addr/data outputs hold their last written value after each pulse.
- `in_ready` is 1 in IDLE, ADDR, COUNT, DATA and CHECK. It is 0 in WRITE, HOLD, DONE and ERROR, and during reset.
- `in_valid` low simply stalls; there is no timeout.
- `core_reset` is 1 in every state except DONE. ERROR keeps the core in reset.
- Reset values: `in_ready` 0; both enables 0; all addr/data 0; `core_reset` 1; `load_done` 0; `load_error` 0. State returns to IDLE.
- `reset` asserted mid-frame:
  - Discards the partial word and the header.
  - Already-committed writes stay in memory.
  - `core_reset` reasserts.

## Timing
- A byte accepted at edge k is registered at edge k.
- If the 4th payload byte is accepted at edge k, the enable is high for the cycle after edge k+1, with addr/data valid in the same cycle.
- Peak throughput is 4 bytes per 5 cycles, because of the WRITE bubble.
- After the last WRITE cycle, HOLD lasts exactly `RELEASE_DELAY` cycles. Then `core_reset` falls and `load_done` rises on the same edge.
- `in_ready` rises the cycle after `reset` deasserts.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the payload, the loader expects one more byte equal to the XOR of all payload bytes.
  - Match → HOLD.
  - Mismatch → ERROR with `load_error` = 1 and `core_reset` held at 1. Committed writes are not undone.
- Undefined: there is no CHECK state, and the last WRITE goes straight to HOLD.

## Structure
- The shared package `mips_pkg` holds:
  - the loader state enum;
  - target codes `TGT_INSTR` = 0x00 and `TGT_DATA` = 0x01;
  - the memory address width (8).
- One natural sub-module, `byte_word_packer`:
  - shift register plus 2-bit byte counter;
  - outputs `word_valid` and `word[31:0]`;
  - reusable by the data-dump path.

## Test plan
- Instruction load: stream 00 10 02 20 01 00 0A 8C 04 00 00.
  - Instr pulses addr 0x10 data 0x2001000A, then addr 0x11 data 0x8C040000.
  - Data port never pulses.
  - `core_reset` falls 2 cycles after the last pulse; `load_done` = 1.
- Wrap: data target, START 0xFF, COUNT 2.
  - Data pulses at 0xFF then 0x00.
- Bad target byte 0x07.
  - `load_error` = 1 and `in_ready` = 0 next cycle; no enables; `core_reset` stays 1.
- Stall: `in_valid` toggled randomly mid-word.
  - Same words and addresses as with an unstalled stream.
  - Each pulse is exactly 1 cycle wide.
- Reset mid-frame after 2 payload bytes, then a full valid frame.
  - Only the second frame's words are written.
- With `IMEM_LOADER_CHECKSUM_EN`, 1-word payload DE AD BE EF:
  - Checksum byte 0x22 → `load_done` = 1.
  - Checksum byte 0x23 → `load_error` = 1 and `core_reset` stays 1.
